slice_compare_sequencer: RTL



---
 rtl/slice_compare_sequencer_if.sv | 19 +
 rtl/slice_compare_sequencer.sv | 95 +++++++++
 2 files changed

// File: rtl/slice_compare_sequencer_if.sv
// Operand/result handshakes and the external 2-bit comparator hookup for
// slice_compare_sequencer.
interface slice_compare_sequencer_if #(parameter int WIDTH = 8);
  logic             in_valid, in_ready;
  logic [WIDTH-1:0] a, b;
  logic [1:0]       slice_a, slice_b;
  logic             slice_lt, slice_eq, slice_gt;
  logic             out_valid, out_ready;
  logic             a_lt_b, a_eq_b, a_gt_b, err, busy;

  modport master (
    output in_valid, a, b, slice_lt, slice_eq, slice_gt, out_ready,
    input  in_ready, slice_a, slice_b, out_valid, a_lt_b, a_eq_b, a_gt_b, err, busy
  );
  modport slave (
    input  in_valid, a, b, slice_lt, slice_eq, slice_gt, out_ready,
    output in_ready, slice_a, slice_b, out_valid, a_lt_b, a_eq_b, a_gt_b, err, busy
  );
endinterface

// File: rtl/slice_compare_sequencer.sv
// MSB-first 2-bit-slice magnitude comparator controller; stops on the first
// differing slice and holds the verdict until the consumer takes it.
module slice_compare_sequencer #(
  parameter int WIDTH = 8
) (
  input logic                    clk,
  input logic                    rst_n,
  slice_compare_sequencer_if.slave bus
);
  localparam int SLICES = WIDTH / 2;
  localparam int IDX_W  = (SLICES > 1) ? $clog2(SLICES) : 1;

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, b_q;
  logic [IDX_W-1:0] idx_q;
  logic             lt_q, eq_q, gt_q, err_q;
  logic             onehot, last, finish;

  // Exactly one flag set: odd parity rules out two, and all three is excluded.
  assign onehot = (bus.slice_lt ^ bus.slice_eq ^ bus.slice_gt) &
                  ~(bus.slice_lt & bus.slice_eq & bus.slice_gt);
  assign last   = (idx_q == '0);
  assign finish = ~onehot | bus.slice_lt | bus.slice_gt | last;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (bus.in_valid)  state_d = SCAN;
      SCAN:    if (finish)        state_d = DONE;
      DONE:    if (bus.out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.in_ready  = (state_q == IDLE);
    bus.out_valid = (state_q == DONE);
    bus.busy      = (state_q != IDLE);
    bus.slice_a   = '0;
    bus.slice_b   = '0;
    if (state_q == SCAN) begin
      bus.slice_a = a_q[2*idx_q +: 2];
      bus.slice_b = b_q[2*idx_q +: 2];
    end
    bus.a_lt_b = lt_q;
    bus.a_eq_b = eq_q;
    bus.a_gt_b = gt_q;
    bus.err    = err_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q   <= '0;
      b_q   <= '0;
      idx_q <= IDX_W'(SLICES - 1);
      lt_q  <= 1'b0;
      eq_q  <= 1'b0;
      gt_q  <= 1'b0;
      err_q <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: if (bus.in_valid) begin
          a_q   <= bus.a;
          b_q   <= bus.b;
          idx_q <= IDX_W'(SLICES - 1);
        end
        SCAN: begin
          if (finish) begin
            // A bad flag set wins over any verdict flags that came with it.
            err_q <= ~onehot;
            lt_q  <= onehot & bus.slice_lt;
            gt_q  <= onehot & bus.slice_gt;
            eq_q  <= onehot & bus.slice_eq;
          end else begin
            idx_q <= idx_q - 1'b1;
          end
        end
        DONE: if (bus.out_ready) begin
          lt_q  <= 1'b0;
          eq_q  <= 1'b0;
          gt_q  <= 1'b0;
          err_q <= 1'b0;
        end
        default: ;
      endcase
    end
  end
endmodule
